mem_arbiter: RTL and testbench

Sequencer/arbiter for the single-port data/instruction RAM shared by the multicycle core.

---
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester (IF/LS) and RAM-side bundle for mem_arbiter.
// Rev 1.0 - initial release
`default_nettype none
`timescale 1ns/1ps

interface mem_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [31:0]       if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [31:0]       ls_wdata;
  logic [1:0]        ls_size;
  logic              ls_unsigned;
  logic              ls_gnt;
  logic              ls_done;
  logic [31:0]       ls_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;

  logic              busy;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_size, ls_unsigned, ram_dout,
    output if_gnt, if_valid, if_rdata, ls_gnt, ls_done, ls_rdata,
           ram_en, ram_we, ram_be, ram_addr, ram_din, busy
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_size, ls_unsigned, ram_dout,
    input  if_gnt, if_valid, if_rdata, ls_gnt, ls_done, ls_rdata,
           ram_en, ram_we, ram_be, ram_addr, ram_din, busy
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// mem_arbiter: IF/LS arbiter and sequencer for a shared single-port RAM.
// Optional macro MEM_ARB_RR_EN selects round-robin on contention. Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  wire logic    clk,
  input  wire logic    rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic       c_OWN_IF = 1'b0;
  localparam logic [1:0] c_LAT    = 2'(RD_LAT);

  state_t              r_state;
  logic                r_owner;
  logic [1:0]          r_cnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_size;
  logic                r_uns;
  logic                r_ram_en;
  logic                r_ram_we;
  logic [3:0]          r_ram_be;
  logic [DATA_W-1:0]   r_ram_din;
  logic                r_if_gnt;
  logic                r_ls_gnt;
  logic                r_if_valid;
  logic                r_ls_done;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_ls_rdata;
  logic                r_busy;
`ifdef MEM_ARB_RR_EN
  logic                r_last_owner;
`endif

  logic                w_sel_ls;
  logic                w_store;
  logic [3:0]          w_be;
  logic [DATA_W-1:0]   w_din;

  function automatic logic [31:0] f_fmt(input logic [31:0] d, input logic [1:0] sz, input logic uns);
    case (sz)
      2'b00:   f_fmt = {{24{~uns & d[7]}}, d[7:0]};
      2'b01:   f_fmt = {{16{~uns & d[15]}}, d[15:0]};
      default: f_fmt = d;
    endcase
  endfunction

  always_comb begin
    w_sel_ls = bus.ls_req;
`ifdef MEM_ARB_RR_EN
    if (bus.ls_req && bus.if_req) w_sel_ls = (r_last_owner == c_OWN_IF);
`endif
  end

  // Lane steering is computed from the live inputs at the IDLE edge so the
  // RAM-side registers already hold their ISSUE values.
  always_comb begin
    w_store = w_sel_ls & bus.ls_we;
    w_be    = 4'b1111;
    w_din   = '0;
    if (w_store) begin
      case (bus.ls_size)
        2'b00: begin
          w_be  = 4'b0001;
          w_din = {24'd0, bus.ls_wdata[7:0]};
        end
        2'b01: begin
          w_be  = 4'b0011;
          w_din = {16'd0, bus.ls_wdata[15:0]};
        end
        default: w_din = bus.ls_wdata;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_owner      <= c_OWN_IF;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_size       <= '0;
      r_uns        <= 1'b0;
      r_ram_en     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_be     <= '0;
      r_ram_din    <= '0;
      r_if_gnt     <= 1'b0;
      r_ls_gnt     <= 1'b0;
      r_if_valid   <= 1'b0;
      r_ls_done    <= 1'b0;
      r_if_rdata   <= '0;
      r_ls_rdata   <= '0;
      r_busy       <= 1'b0;
`ifdef MEM_ARB_RR_EN
      r_last_owner <= c_OWN_IF;
`endif
    end else begin
      r_ram_en   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_if_valid <= 1'b0;
      r_ls_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.if_req || bus.ls_req) begin
            r_state   <= S_ISSUE;
            r_owner   <= w_sel_ls;
            r_we      <= w_store;
            r_addr    <= w_sel_ls ? bus.ls_addr : bus.if_addr;
            r_size    <= bus.ls_size;
            r_uns     <= bus.ls_unsigned;
            r_ram_en  <= 1'b1;
            r_ram_we  <= w_store;
            r_ram_be  <= w_be;
            r_ram_din <= w_din;
            r_ls_gnt  <= w_sel_ls;
            r_if_gnt  <= ~w_sel_ls;
            r_busy    <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (r_we) begin
            r_state   <= S_DONE;
            r_ls_done <= 1'b1;
          end else begin
            r_state <= S_WAIT;
            r_cnt   <= c_LAT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 2'd1) begin
            r_state <= S_DONE;
            if (r_owner != c_OWN_IF) begin
              r_ls_done  <= 1'b1;
              r_ls_rdata <= f_fmt(bus.ram_dout, r_size, r_uns);
            end else begin
              r_if_valid <= 1'b1;
              r_if_rdata <= bus.ram_dout;
            end
          end
          r_cnt <= r_cnt - 2'd1;
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          r_if_gnt <= 1'b0;
          r_ls_gnt <= 1'b0;
          r_busy   <= 1'b0;
`ifdef MEM_ARB_RR_EN
          r_last_owner <= r_owner;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ram_en   = r_ram_en;
  assign bus.ram_we   = r_ram_we;
  assign bus.ram_be   = r_ram_be;
  assign bus.ram_addr = r_addr;
  assign bus.ram_din  = r_ram_din;
  assign bus.if_gnt   = r_if_gnt;
  assign bus.ls_gnt   = r_ls_gnt;
  assign bus.if_valid = r_if_valid;
  assign bus.ls_done  = r_ls_done;
  assign bus.if_rdata = r_if_rdata;
  assign bus.ls_rdata = r_ls_rdata;
  assign bus.busy     = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter (RD_LAT=1 and RD_LAT=3 instances).
// Rev 1.0 - initial release
`default_nettype none
`timescale 1ns/1ps

module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic both_gnt_seen = 1'b0;
  logic preload_done  = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(8)) bus_a ();
  mem_arbiter_if #(.ADDR_W(8)) bus_b ();

  mem_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(1)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  mem_arbiter #(.ADDR_W(8), .DATA_W(32), .RD_LAT(3)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // RAM A: one-cycle synchronous read, byte-lane writes.
  logic [31:0] mem_a [0:255];
  logic [31:0] dout_a = '0;
  always @(posedge clk) begin
    if (!preload_done) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= 32'h0;
      mem_a[4]     <= 32'h00500093;
      preload_done <= 1'b1;
    end else if (bus_a.ram_en) begin
      if (bus_a.ram_we) begin
        for (int b = 0; b < 4; b++)
          if (bus_a.ram_be[b]) mem_a[bus_a.ram_addr][b*8 +: 8] <= bus_a.ram_din[b*8 +: 8];
      end else begin
        dout_a <= mem_a[bus_a.ram_addr];
      end
    end
  end
  assign bus_a.ram_dout = dout_a;

  // RAM B: read-only, three-cycle read pipeline.
  logic [31:0] p1 = '0, p2 = '0, p3 = '0;
  always @(posedge clk) begin
    if (bus_b.ram_en) p1 <= (bus_b.ram_addr == 8'hFF) ? 32'hCAFEF00D : {24'h0, bus_b.ram_addr};
    p2 <= p1;
    p3 <= p2;
  end
  assign bus_b.ram_dout = p3;

  always @(negedge clk) if (bus_a.if_gnt && bus_a.ls_gnt) both_gnt_seen = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ls(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [7:0] addr, input logic [31:0] wd);
    bus_a.ls_req = 1'b1;  bus_a.ls_we = we;   bus_a.ls_size = sz;
    bus_a.ls_unsigned = uns; bus_a.ls_addr = addr; bus_a.ls_wdata = wd;
  endtask

  task automatic do_store(input string tag, input logic [1:0] sz, input logic [7:0] addr,
                          input logic [31:0] wd, input logic [3:0] be, input logic [31:0] din);
    set_ls(1'b1, sz, 1'b0, addr, wd);
    tick();
    check({tag, "_gnt"},  {31'b0, bus_a.ls_gnt}, 32'd1);
    check({tag, "_en"},   {31'b0, bus_a.ram_en}, 32'd1);
    check({tag, "_we"},   {31'b0, bus_a.ram_we}, 32'd1);
    check({tag, "_addr"}, {24'b0, bus_a.ram_addr}, {24'b0, addr});
    check({tag, "_be"},   {28'b0, bus_a.ram_be}, {28'b0, be});
    check({tag, "_din"},  bus_a.ram_din, din);
    tick();
    check({tag, "_done"}, {31'b0, bus_a.ls_done}, 32'd1);
    check({tag, "_we_off"}, {31'b0, bus_a.ram_we}, 32'd0);
    bus_a.ls_req = 1'b0;
    tick();
    check({tag, "_done_pulse"}, {31'b0, bus_a.ls_done}, 32'd0);
  endtask

  task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                         input logic [7:0] addr, input logic [31:0] exp);
    set_ls(1'b0, sz, uns, addr, 32'h0);
    tick();
    check({tag, "_we"}, {31'b0, bus_a.ram_we}, 32'd0);
    check({tag, "_be"}, {28'b0, bus_a.ram_be}, 32'hF);
    tick();
    check({tag, "_early"}, {31'b0, bus_a.ls_done}, 32'd0);
    tick();
    check({tag, "_done"},  {31'b0, bus_a.ls_done}, 32'd1);
    check({tag, "_rdata"}, bus_a.ls_rdata, exp);
    bus_a.ls_req = 1'b0;
    tick();
  endtask

  logic exp_ls;

  initial begin
    bus_a.if_req = 0; bus_a.if_addr = 0; bus_a.ls_req = 0; bus_a.ls_we = 0;
    bus_a.ls_addr = 0; bus_a.ls_wdata = 0; bus_a.ls_size = 0; bus_a.ls_unsigned = 0;
    bus_b.if_req = 0; bus_b.if_addr = 0; bus_b.ls_req = 0; bus_b.ls_we = 0;
    bus_b.ls_addr = 0; bus_b.ls_wdata = 0; bus_b.ls_size = 0; bus_b.ls_unsigned = 0;

    tick(); tick();
    check("rst_busy",   {31'b0, bus_a.busy},   32'd0);
    check("rst_ram_en", {31'b0, bus_a.ram_en}, 32'd0);
    check("rst_gnt",    {30'b0, bus_a.if_gnt, bus_a.ls_gnt}, 32'd0);
    check("rst_rdata",  bus_a.if_rdata, 32'd0);
    rst = 1'b1;
    tick();

    // Fetch aborted by reset during WAIT, then retried.
    bus_a.if_req = 1'b1; bus_a.if_addr = 8'h04;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("midrst_busy",   {31'b0, bus_a.busy},     32'd0);
    check("midrst_ram_en", {31'b0, bus_a.ram_en},   32'd0);
    check("midrst_if_gnt", {31'b0, bus_a.if_gnt},   32'd0);
    check("midrst_valid",  {31'b0, bus_a.if_valid}, 32'd0);
    rst = 1'b1;
    tick();
    check("f1_issue_en",   {31'b0, bus_a.ram_en},   32'd1);
    check("f1_issue_addr", {24'b0, bus_a.ram_addr}, 32'h04);
    check("f1_issue_gnt",  {31'b0, bus_a.if_gnt},   32'd1);
    tick();
    check("f1_early",      {31'b0, bus_a.if_valid}, 32'd0);
    tick();
    check("f1_valid",      {31'b0, bus_a.if_valid}, 32'd1);
    check("f1_rdata",      bus_a.if_rdata, 32'h00500093);
    bus_a.if_req = 1'b0;
    tick();
    check("f1_valid_pulse", {31'b0, bus_a.if_valid}, 32'd0);
    check("f1_idle_busy",   {31'b0, bus_a.busy},     32'd0);

    do_store("st_byte", 2'b00, 8'h10, 32'hDEADBEEF, 4'b0001, 32'h000000EF);
    do_store("st_half", 2'b01, 8'h20, 32'h12345678, 4'b0011, 32'h00005678);
    do_store("st_word", 2'b10, 8'h10, 32'h000080F0, 4'b1111, 32'h000080F0);

    do_load("ld_b_s",  2'b00, 1'b0, 8'h10, 32'hFFFFFFF0);
    do_load("ld_h_u",  2'b01, 1'b1, 8'h10, 32'h000080F0);
    do_load("ld_h_s",  2'b01, 1'b0, 8'h10, 32'hFFFF80F0);
    do_load("ld_b_u",  2'b00, 1'b1, 8'h10, 32'h000000F0);
    do_load("ld_w11",  2'b11, 1'b0, 8'h10, 32'h000080F0);
    do_load("ld_half", 2'b10, 1'b0, 8'h20, 32'h00005678);

    // Simultaneous requests: LS first, IF served afterwards.
    set_ls(1'b0, 2'b10, 1'b0, 8'h10, 32'h0);
    bus_a.if_req = 1'b1; bus_a.if_addr = 8'h04;
    tick();
    check("both_ls_gnt", {31'b0, bus_a.ls_gnt}, 32'd1);
    check("both_if_gnt", {31'b0, bus_a.if_gnt}, 32'd0);
    tick(); tick();
    check("both_ls_done",  {31'b0, bus_a.ls_done}, 32'd1);
    check("both_ls_rdata", bus_a.ls_rdata, 32'h000080F0);
    bus_a.ls_req = 1'b0;
    tick();
    check("both_idle_gnt", {30'b0, bus_a.if_gnt, bus_a.ls_gnt}, 32'd0);
    tick();
    check("both_if_gnt2", {31'b0, bus_a.if_gnt}, 32'd1);
    check("both_ls_gnt2", {31'b0, bus_a.ls_gnt}, 32'd0);
    tick(); tick();
    check("both_if_valid", {31'b0, bus_a.if_valid}, 32'd1);
    check("both_if_rdata", bus_a.if_rdata, 32'h00500093);
    check("both_ls_hold",  bus_a.ls_rdata, 32'h000080F0);
    bus_a.if_req = 1'b0;
    tick();

    // Both requests held for four transactions, last owner is IF.
    set_ls(1'b0, 2'b10, 1'b0, 8'h10, 32'h0);
    bus_a.if_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
`ifdef MEM_ARB_RR_EN
      exp_ls = (i % 2 == 0);
`else
      exp_ls = 1'b1;
`endif
      check("hold_ls_gnt", {31'b0, bus_a.ls_gnt}, {31'b0, exp_ls});
      check("hold_if_gnt", {31'b0, bus_a.if_gnt}, {31'b0, ~exp_ls});
      tick(); tick();
      check("hold_ls_done",  {31'b0, bus_a.ls_done},  {31'b0, exp_ls});
      check("hold_if_valid", {31'b0, bus_a.if_valid}, {31'b0, ~exp_ls});
      if (i == 3) begin
        bus_a.ls_req = 1'b0;
        bus_a.if_req = 1'b0;
      end
      tick();
    end

    // RD_LAT=3 fetch at the top address.
    bus_b.if_req = 1'b1; bus_b.if_addr = 8'hFF;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) begin
        check("l3_en",   {31'b0, bus_b.ram_en},   32'd1);
        check("l3_addr", {24'b0, bus_b.ram_addr}, 32'hFF);
      end
      check("l3_valid", {31'b0, bus_b.if_valid}, {31'b0, c == 5});
      check("l3_busy",  {31'b0, bus_b.busy},     {31'b0, c <= 5});
      if (c == 5) begin
        check("l3_rdata", bus_b.if_rdata, 32'hCAFEF00D);
        bus_b.if_req = 1'b0;
      end
    end

    check("gnt_exclusive", {31'b0, both_gnt_seen}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
